ram_clear_sched: RTL and testbench

- Sequences the power-on RAM-clear writes for the menu core: SDRAM and DDR3 are both zero-filled while the menu runs, so later cores start with clean RAM.
- Replaces the free-running write strobe and address counter with a start/abort-controlled scheduler that has two independent channels.
- SDRAM channel: paced single-cycle write strobes over 0..sdr_end.
- DDR3 channel: Avalon-style held write requests, gated by ddr_busy, over ddr_base..ddr_base+ddr_words-1.
- Sits between hps_io/top control and the sdram/ddram write ports; data is always zero and is driven outside this block.

---
 rtl/ram_clear_sched.sv | 135 +++++++++++++
 tb/tb_ram_clear_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_clear_sched.sv
// Power-on RAM-clear scheduler: paced SDRAM strobes plus Avalon-style DDR3 requests,
// started and aborted by single-cycle pulses from the menu core control path.
//
// state    | meaning
// T_IDLE   | no pass running (may still drain one held DDR3 write after abort)
// T_RUN    | clear pass in progress
// S_IDLE   | SDRAM channel idle
// S_RUN    | SDRAM channel pacing strobes with the gap counter
// S_FIN    | SDRAM channel finished, waiting for DDR3 channel
// D_IDLE   | DDR3 channel idle
// D_REQ    | DDR3 write request held on ddr_we
// D_FIN    | DDR3 channel finished, waiting for SDRAM channel
module ram_clear_sched #(
  parameter int SDR_AW  = 25,
  parameter int DDR_AW  = 29,
  parameter int SDR_GAP = 32
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SDR_AW-1:0] sdr_end,
  input  logic [DDR_AW-1:0] ddr_base,
  input  logic [DDR_AW-1:0] ddr_words,
  output logic              sdr_we,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              ddr_we,
  output logic [DDR_AW-1:0] ddr_addr,
  input  logic              ddr_busy,
  output logic              busy,
  output logic              done
);

  localparam int GW = $clog2(SDR_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(SDR_GAP - 1);

  typedef enum logic       {T_IDLE, T_RUN} top_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} sdr_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_FIN} ddr_t;

  top_t t_state, t_nx;
  sdr_t s_state, s_nx, s_st_nx;
  ddr_t d_state, d_nx, d_st_nx;

  logic [GW-1:0]     gap;
  logic [SDR_AW-1:0] sdr_last;
  logic [DDR_AW-1:0] remaining;
  logic              ab_pend;
  logic              go, stop, ddr_acc, fin_all;

  assign sdr_we  = (s_state == S_RUN) && (gap == GAP_LAST);
  assign ddr_we  = (d_state == D_REQ);
  assign ddr_acc = ddr_we && !ddr_busy;
  // A start is refused while an aborted DDR3 write is still draining.
  assign go      = start && (t_state == T_IDLE) && !busy;
  assign stop    = abort && (t_state == T_RUN);

  always_comb begin
    s_nx = s_state;
    case (s_state)
      S_IDLE:  if (go) s_nx = S_RUN;
      S_RUN:   if (stop) s_nx = S_IDLE;
               else if (sdr_we && (sdr_addr == sdr_last)) s_nx = S_FIN;
      S_FIN:   if (stop) s_nx = S_IDLE;
      default: s_nx = S_IDLE;
    endcase

    d_nx = d_state;
    case (d_state)
      D_IDLE:  if (go) d_nx = (ddr_words == '0) ? D_FIN : D_REQ;
      D_REQ:   if (stop) d_nx = ddr_busy ? D_REQ : D_IDLE;
               else if (ab_pend) begin
                 if (ddr_acc) d_nx = D_IDLE;
               end
               else if (ddr_acc && (remaining == DDR_AW'(1))) d_nx = D_FIN;
      D_FIN:   if (stop) d_nx = D_IDLE;
      default: d_nx = D_IDLE;
    endcase

    fin_all = (t_state == T_RUN) && !stop && (s_nx == S_FIN) && (d_nx == D_FIN);
    s_st_nx = fin_all ? S_IDLE : s_nx;
    d_st_nx = fin_all ? D_IDLE : d_nx;

    t_nx = t_state;
    case (t_state)
      T_IDLE:  if (go) t_nx = T_RUN;
      T_RUN:   if (stop || fin_all) t_nx = T_IDLE;
      default: t_nx = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      t_state   <= T_IDLE;
      s_state   <= S_IDLE;
      d_state   <= D_IDLE;
      gap       <= '0;
      sdr_addr  <= '0;
      sdr_last  <= '0;
      ddr_addr  <= '0;
      remaining <= '0;
      ab_pend   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      t_state <= t_nx;
      s_state <= s_st_nx;
      d_state <= d_st_nx;
      ab_pend <= (d_st_nx == D_REQ) && (ab_pend || stop);
      busy    <= (t_nx == T_RUN) || (d_st_nx != D_IDLE);

      if (go) done <= 1'b0;
      else if (fin_all) done <= 1'b1;

      if (go) gap <= '0;
      else if (s_state == S_RUN) gap <= (gap == GAP_LAST) ? '0 : gap + 1'b1;

      if (go) begin
        sdr_addr <= '0;
        sdr_last <= sdr_end;
      end else if (sdr_we && (sdr_addr != sdr_last)) begin
        sdr_addr <= sdr_addr + 1'b1;
      end

      if (go) begin
        ddr_addr  <= ddr_base;
        remaining <= ddr_words;
      end else if (ddr_acc) begin
        ddr_addr  <= ddr_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_clear_sched.sv
// Directed bench for ram_clear_sched: expected strobe/accept cycles and addresses are
// queued when a pass is launched and checked by a monitor as the DUT writes.
module tb_ram_clear_sched;

  localparam int SAW = 25;
  localparam int DAW = 29;
  localparam int GAP = 4;

  logic           clk_sys = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [SAW-1:0] sdr_end = '0;
  logic [DAW-1:0] ddr_base = '0;
  logic [DAW-1:0] ddr_words = '0;
  logic           ddr_busy = 1'b0;
  logic           sdr_we, ddr_we, busy, done;
  logic [SAW-1:0] sdr_addr;
  logic [DAW-1:0] ddr_addr;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
  } exp_t;

  exp_t sdr_q[$];
  exp_t ddr_q[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;

  ram_clear_sched #(.SDR_AW(SAW), .DDR_AW(DAW), .SDR_GAP(GAP)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .sdr_end  (sdr_end),
    .ddr_base (ddr_base),
    .ddr_words(ddr_words),
    .sdr_we   (sdr_we),
    .sdr_addr (sdr_addr),
    .ddr_we   (ddr_we),
    .ddr_addr (ddr_addr),
    .ddr_busy (ddr_busy),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every SDRAM strobe and every DDR3 accept must match the queue head.
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n) begin
      if (sdr_we) begin
        if (sdr_q.size() == 0) check("sdr_unexpected_strobe", 64'(sdr_q.size()), 64'd1);
        else begin
          e = sdr_q.pop_front();
          check("sdr_strobe_cycle", 64'(cyc), 64'(e.cyc));
          check("sdr_strobe_addr", 64'(sdr_addr), e.addr);
        end
      end
      if (ddr_we && !ddr_busy) begin
        if (ddr_q.size() == 0) check("ddr_unexpected_accept", 64'(ddr_q.size()), 64'd1);
        else begin
          e = ddr_q.pop_front();
          check("ddr_accept_cycle", 64'(cyc), 64'(e.cyc));
          check("ddr_accept_addr", 64'(ddr_addr), e.addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(input int se, input int base, input int words, output int e);
    sdr_end   = SAW'(se);
    ddr_base  = DAW'(base);
    ddr_words = DAW'(words);
    start     = 1'b1;
    tick();
    start = 1'b0;
    e     = cyc;
  endtask

  task automatic push_sdr(input int e, input int se);
    for (int k = 0; k <= se; k++) sdr_q.push_back('{e + GAP - 1 + k * GAP, 64'(k)});
  endtask

  task automatic push_ddr(input int e, input int base, input int words);
    for (int k = 0; k < words; k++) ddr_q.push_back('{e + k, 64'(DAW'(base + k))});
  endtask

  task automatic wait_idle(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_sdr_left"}, 64'(sdr_q.size()), 64'd0);
    check({tag, "_ddr_left"}, 64'(ddr_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sdr_we"}, 64'(sdr_we), 64'd0);
    check({tag, "_ddr_we"}, 64'(ddr_we), 64'd0);
    check({tag, "_sdr_addr"}, 64'(sdr_addr), 64'd0);
    check({tag, "_ddr_addr"}, 64'(ddr_addr), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int e, when;

    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // SDRAM only: four strobes, done one cycle after the last strobe.
    do_start(3, 0, 0, e);
    push_sdr(e, 3);
    check("p1_busy_set", 64'(busy), 64'd1);
    wait_idle(100, when);
    check("p1_done_cycle", 64'(when), 64'(e + GAP * 4));
    check("p1_done", 64'(done), 64'd1);
    check_queues_empty("p1");

    // DDR3 three words back to back, SDRAM single strobe.
    do_start(0, 'h100, 3, e);
    push_ddr(e, 'h100, 3);
    push_sdr(e, 0);
    wait_idle(100, when);
    check("p2_done_cycle", 64'(when), 64'(e + GAP));
    check("p2_done", 64'(done), 64'd1);
    check_queues_empty("p2");

    // DDR3 stall: second word held under ddr_busy.
    do_start(0, 'h100, 2, e);
    push_sdr(e, 0);
    ddr_q.push_back('{e, 64'h100});
    ddr_q.push_back('{e + 5, 64'h101});
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) ddr_busy = 1'b1;
      if (k == 4) begin
        tick();
        ddr_busy = 1'b0;
      end
      check("p3_hold_we", 64'(ddr_we), 64'd1);
      check("p3_hold_addr", 64'(ddr_addr), 64'h101);
    end
    tick();
    check("p3_we_dropped", 64'(ddr_we), 64'd0);
    check("p3_done", 64'(done), 64'd1);
    check("p3_busy", 64'(busy), 64'd0);
    check_queues_empty("p3");

    // Abort while a DDR3 write is stalled: the held write completes, nothing else.
    do_start(10, 'h200, 100, e);
    push_ddr(e, 'h200, 2);
    ddr_q.push_back('{e + 5, 64'h202});
    tick();
    tick();
    ddr_busy = 1'b1;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    check("p4_abort_we", 64'(ddr_we), 64'd1);
    check("p4_abort_addr", 64'(ddr_addr), 64'h202);
    check("p4_abort_busy", 64'(busy), 64'd1);
    tick();
    check("p4_abort_we2", 64'(ddr_we), 64'd1);
    tick();
    ddr_busy = 1'b0;
    tick();
    check("p4_we_dropped", 64'(ddr_we), 64'd0);
    check("p4_busy", 64'(busy), 64'd0);
    check("p4_done", 64'(done), 64'd0);
    for (int k = 0; k < 3 * GAP; k++) tick();
    check_queues_empty("p4");

    // Second start mid-pass is ignored.
    do_start(2, 'h300, 3, e);
    push_sdr(e, 2);
    push_ddr(e, 'h300, 3);
    tick();
    sdr_end  = SAW'(7);
    ddr_base = DAW'('h999);
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(100, when);
    check("p5_done_cycle", 64'(when), 64'(e + GAP * 3));
    check("p5_done", 64'(done), 64'd1);
    check_queues_empty("p5");

    // Abort in idle is ignored; start+abort together in idle starts a pass.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_done", 64'(done), 64'd1);
    abort = 1'b1;
    do_start(1, 0, 0, e);
    abort = 1'b0;
    push_sdr(e, 1);
    check("p6_busy", 64'(busy), 64'd1);
    check("p6_done_cleared", 64'(done), 64'd0);
    check("p6_sdr_addr", 64'(sdr_addr), 64'd0);
    wait_idle(100, when);
    check("p6_done_cycle", 64'(when), 64'(e + GAP * 2));
    check("p6_done", 64'(done), 64'd1);
    check_queues_empty("p6");

    // Asynchronous reset mid-pass with a held DDR3 request.
    do_start(5, 'h400, 50, e);
    ddr_busy = 1'b1;
    tick();
    check("p7_we_before_reset", 64'(ddr_we), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    ddr_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    do_start(1, 'h10, 2, e);
    push_sdr(e, 1);
    push_ddr(e, 'h10, 2);
    wait_idle(100, when);
    check("p8_done_cycle", 64'(when), 64'(e + GAP * 2));
    check("p8_done", 64'(done), 64'd1);
    check_queues_empty("p8");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
